// File: rtl/roic_pkg.sv
// Shared constants, index-width helper and readout FSM state type for the ROIC pixel readout.
package roic_pkg;

    localparam int unsigned NCOL  = 640;
    localparam int unsigned NROW  = 512;
    localparam int unsigned DW    = 14;
    localparam int unsigned COL_W = $clog2(NCOL);
    localparam int unsigned ROW_W = $clog2(NROW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } roic_state_e;

    // Index width for an n-wide one-hot vector, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with an exactly-one-bit-set qualifier.
module onehot_enc #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = roic_pkg::idx_w(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx_c,
    output logic          one_c
);

    // OR of set-bit positions; only meaningful when one_c is high.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (vec[i]) begin
                idx_c = idx_c | IW'(i);
            end
        end
    end

    assign one_c = (vec != '0) && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/roic_pixel_readout.sv
// Pixel readout: encodes scanner enables, tags frame markers and buffers samples
// in a small FIFO with a valid/ready output and frame accounting.
module roic_pixel_readout #(
    parameter int unsigned NCOL  = roic_pkg::NCOL,
    parameter int unsigned NROW  = roic_pkg::NROW,
    parameter int unsigned DW    = roic_pkg::DW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCOL-1:0]         col_enable,
    input  logic [NROW-1:0]         row_enable,
    input  logic                    scan_done,
    input  logic [DW-1:0]           adc_data,
    input  logic                    adc_valid,
    output logic [DW-1:0]           pix_data,
    output logic [$clog2(NROW)-1:0] pix_row,
    output logic [$clog2(NCOL)-1:0] pix_col,
    output logic                    pix_sof,
    output logic                    pix_eol,
    output logic                    pix_eof,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    onehot_err,
    output logic                    overflow,
    output logic [15:0]             frame_cnt
);

    import roic_pkg::roic_state_e;
    import roic_pkg::ST_IDLE;
    import roic_pkg::ST_ACTIVE;
    import roic_pkg::ST_FLUSH;

    localparam int unsigned RW = $clog2(NROW);
    localparam int unsigned CW = $clog2(NCOL);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned NW = PW + 1;
    localparam int unsigned EW = DW + RW + CW + 3;

    roic_state_e   state, state_nxt;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          row_one, col_one;
    logic          well_formed, sof_c, eol_c, eof_c;
    logic          push_req, push_ok, pop, full;
    logic [NW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;

    onehot_enc #(.W(NROW), .IW(RW)) u_row_enc (
        .vec   (row_enable),
        .idx_c (row_idx),
        .one_c (row_one)
    );

    onehot_enc #(.W(NCOL), .IW(CW)) u_col_enc (
        .vec   (col_enable),
        .idx_c (col_idx),
        .one_c (col_one)
    );

    assign well_formed = adc_valid && row_one && col_one;
    assign sof_c       = (row_idx == '0) && (col_idx == '0);
    assign eol_c       = (col_idx == CW'(NCOL - 1));
    assign eof_c       = eol_c && (row_idx == RW'(NROW - 1));

    assign full    = (count == NW'(DEPTH));
    assign pix_valid = (count != '0);
    assign pop     = pix_valid && pix_ready;
    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    assign push_ok = push_req && (!full || pop);

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and push qualification.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (well_formed && sof_c) begin
                    push_req  = 1'b1;
                    state_nxt = eof_c ? ST_FLUSH : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                push_req = well_formed;
                if ((well_formed && eof_c) || scan_done) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (count == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care until a push makes them visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {adc_data, row_idx, col_idx, sof_c, eol_c, eof_c};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + NW'(1);
            end else if (pop && !push_ok) begin
                count <= count - NW'(1);
            end
        end
    end

    // Status: error pulse, sticky overflow, delivered-frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            onehot_err <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            onehot_err <= (state == ST_ACTIVE) && adc_valid && !(row_one && col_one);
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && head[0]) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Head word drives the outputs; forced to zero whenever nothing is valid.
    assign head = mem[rd_ptr];
    assign {pix_data, pix_row, pix_col, pix_sof, pix_eol, pix_eof} = pix_valid ? head : '0;

endmodule

// File: tb/tb_roic_pixel_readout.sv
// Randomised bench for roic_pixel_readout against a queue-based frame model.
module tb_roic_pixel_readout;

    localparam int unsigned NCOL  = 8;
    localparam int unsigned NROW  = 4;
    localparam int unsigned DW    = 14;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = $clog2(NROW);
    localparam int unsigned CW    = $clog2(NCOL);

    logic            clk = 1'b0;
    logic            rst;
    logic [NCOL-1:0] col_enable;
    logic [NROW-1:0] row_enable;
    logic            scan_done;
    logic [DW-1:0]   adc_data;
    logic            adc_valid;
    logic [DW-1:0]   pix_data;
    logic [RW-1:0]   pix_row;
    logic [CW-1:0]   pix_col;
    logic            pix_sof, pix_eol, pix_eof, pix_valid, pix_ready;
    logic            onehot_err, overflow;
    logic [15:0]     frame_cnt;

    roic_pixel_readout #(.NCOL(NCOL), .NROW(NROW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .col_enable (col_enable),
        .row_enable (row_enable),
        .scan_done  (scan_done),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .pix_data   (pix_data),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .onehot_err (onehot_err),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            r;
        int            c;
        bit            sof, eol, eof;
    } word_t;

    // Model: 0 = waiting for frame start, 1 = in frame, 2 = draining.
    word_t q[$];
    int    mode;
    bit    m_err, m_ovf;
    int    m_frames;
    int    n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NROW-1:0] roh(input int r);
        logic [NROW-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [NCOL-1:0] coh(input int c);
        logic [NCOL-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        mode     = 0;
        m_err    = 1'b0;
        m_ovf    = 1'b0;
        m_frames = 0;
    endtask

    task automatic compare_outputs();
        check("pix_valid", 32'(pix_valid), 32'(q.size() > 0));
        if (q.size() > 0 && pix_valid) begin
            check("pix_data", 32'(pix_data), 32'(q[0].d));
            check("pix_row",  32'(pix_row),  32'(q[0].r));
            check("pix_col",  32'(pix_col),  32'(q[0].c));
            check("pix_sof",  32'(pix_sof),  32'(q[0].sof));
            check("pix_eol",  32'(pix_eol),  32'(q[0].eol));
            check("pix_eof",  32'(pix_eof),  32'(q[0].eof));
        end
        check("onehot_err", 32'(onehot_err), 32'(m_err));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("frame_cnt",  32'(frame_cnt),  32'(m_frames & 16'hFFFF));
    endtask

    // Predict the effect of the coming clock edge from the frame rules.
    task automatic model_step(input logic v, input logic [NROW-1:0] re, input logic [NCOL-1:0] ce,
                              input logic [DW-1:0] d, input logic rdy, input logic sd);
        bit    wf, pop, acc;
        int    r, c, pre;
        word_t w;
        r = -1;
        c = -1;
        for (int i = 0; i < int'(NROW); i++) if (re[i]) r = i;
        for (int i = 0; i < int'(NCOL); i++) if (ce[i]) c = i;
        wf    = v && ($countones(re) == 1) && ($countones(ce) == 1);
        w.d   = d;
        w.r   = r;
        w.c   = c;
        w.sof = (r == 0) && (c == 0);
        w.eol = (c == int'(NCOL) - 1);
        w.eof = w.eol && (r == int'(NROW) - 1);
        pre   = q.size();
        pop   = (pre > 0) && rdy;
        acc   = (mode == 0 && wf && w.sof) || (mode == 1 && wf);
        m_err = v && (mode == 1) && !wf;
        if (pop) begin
            if (q[0].eof) m_frames++;
            void'(q.pop_front());
        end
        if (acc) begin
            if (pre < int'(DEPTH) || pop) q.push_back(w);
            else m_ovf = 1'b1;
        end
        case (mode)
            0: if (acc) mode = w.eof ? 2 : 1;
            1: if ((acc && w.eof) || sd) mode = 2;
            default: if (pre == 0) mode = 0;
        endcase
    endtask

    // One cycle: check current outputs, drive inputs, advance the model.
    task automatic cyc(input logic v, input logic [NROW-1:0] re, input logic [NCOL-1:0] ce,
                       input logic [DW-1:0] d, input logic rdy, input logic sd);
        compare_outputs();
        adc_valid  = v;
        row_enable = re;
        col_enable = ce;
        adc_data   = d;
        pix_ready  = rdy;
        scan_done  = sd;
        model_step(v, re, ce, d, rdy, sd);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_data"},  32'(pix_data),  32'd0);
        check({tag, "_row"},   32'(pix_row),   32'd0);
        check({tag, "_col"},   32'(pix_col),   32'd0);
        check({tag, "_mark"},  32'({pix_sof, pix_eol, pix_eof}), 32'd0);
        check({tag, "_err"},   32'(onehot_err), 32'd0);
        check({tag, "_ovf"},   32'(overflow),   32'd0);
        check({tag, "_frm"},   32'(frame_cnt),  32'd0);
    endtask

    logic [NROW-1:0] re_r;
    logic [NCOL-1:0] ce_r;
    logic            v_r, rdy_r, sd_r;
    int              k, pr, pc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        adc_valid = 1'b0; row_enable = '0; col_enable = '0;
        adc_data = '0; pix_ready = 1'b0; scan_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        // Row 0, columns 0..3 with ready held high.
        for (int c = 0; c < 4; c++) cyc(1'b1, roh(0), coh(c), DW'(14'h100 + c), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Malformed column enables while in frame.
        cyc(1'b1, roh(0), '0, DW'(14'h0AA), 1'b1, 1'b0);
        idle(2, 1'b1);
        cyc(1'b1, roh(0), coh(4) | coh(5), DW'(14'h0BB), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Six samples against a stalled output, then drain.
        for (int i = 0; i < 6; i++)
            cyc(1'b1, roh((4 + i) / 8), coh((4 + i) % 8), DW'(14'h200 + i), 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // Abort frame with scan_done, then one complete frame.
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int r = 0; r < int'(NROW); r++)
            for (int c = 0; c < int'(NCOL); c++)
                cyc(1'b1, roh(r), coh(c), DW'(r * 16 + c + 14'h300), 1'b1, 1'b0);
        idle(3, 1'b1);
        cyc(1'b1, roh(1), coh(1), DW'(14'h3FF), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Three words buffered, then reset mid-frame.
        for (int c = 0; c < 3; c++) cyc(1'b1, roh(0), coh(c), DW'(14'h400 + c), 1'b0, 1'b0);
        compare_outputs();
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        adc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, roh(0), coh(3), DW'(14'h500), 1'b1, 1'b0);
        cyc(1'b1, roh(1), coh(0), DW'(14'h501), 1'b1, 1'b0);
        idle(2, 1'b1);
        cyc(1'b1, roh(0), coh(0), DW'(14'h502), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Randomised scanning with gaps, stalls, strays and early scan_done.
        pr = 0;
        pc = 1;
        for (int n = 0; n < 3000; n++) begin
            v_r   = ($urandom_range(0, 3) != 0);
            rdy_r = ($urandom_range(0, 4) != 0);
            sd_r  = ($urandom_range(0, 199) == 0);
            k     = $urandom_range(0, 19);
            if (k < 17) begin
                re_r = roh(pr);
                ce_r = coh(pc);
                if (v_r) begin
                    pc = pc + 1;
                    if (pc == int'(NCOL)) begin
                        pc = 0;
                        pr = (pr + 1) % int'(NROW);
                    end
                end
            end else if (k < 19) begin
                re_r = roh($urandom_range(0, NROW - 1));
                ce_r = coh($urandom_range(0, NCOL - 1));
            end else begin
                re_r = roh(pr);
                ce_r = ($urandom_range(0, 1) == 0) ? '0 : (coh(0) | coh(NCOL - 1));
            end
            cyc(v_r, re_r, ce_r, DW'($urandom), rdy_r, sd_r);
        end
        idle(8, 1'b1);
        compare_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
